// File: rtl/fetch_stage_if.sv
// Bundles the fetch stage's downstream, redirect and instruction-ROM signals.
//
// Flow control: the fetch stage presents an instruction whenever if_valid=1.
// The consumer takes it on any rising edge where if_valid=1 and stall=0.
// While stall=1 and if_valid=1, if_pc/if_inst are held unchanged. redirect
// needs no acknowledgement and takes effect on the edge where it is sampled.
// The ROM registers imem_addr and returns imem_inst one cycle later.
interface fetch_stage_if;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] fetch_count;

    // Fetch stage side.
    modport master (
        input  stall, redirect, redirect_pc, imem_inst,
        output imem_addr, if_valid, if_pc, if_inst, fetch_count
    );

    // Pipeline and ROM side.
    modport slave (
        output stall, redirect, redirect_pc, imem_inst,
        input  imem_addr, if_valid, if_pc, if_inst, fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage for a registered-address instruction ROM.
// It drives the ROM address and presents the returned word downstream with its
// PC. The stage handles stall holds, redirects, and counts delivered
// instructions.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic           clk,
    input  logic           rst,
    fetch_stage_if.master  bus
);

    logic [29:0] r_fetch_pc;     // next sequential word address
    logic [29:0] r_pc_d;         // word address of the word now on imem_inst
    logic        r_valid_d;      // imem_inst holds a real instruction
    logic [31:0] r_fetch_count;

    logic [29:0] w_imem_addr;
    logic        w_unused;

    // The two alignment bits of a redirect target are dropped.
    assign w_unused = &{1'b0, bus.redirect_pc[1:0]};

    // Select the ROM address. Reset wins, then redirect. A stall re-reads the
    // word on display so that it stays on imem_inst. A bubble is never held.
    always_comb begin
        w_imem_addr = r_fetch_pc;
        if (rst) begin
            w_imem_addr = RESET_PC[31:2];
        end else if (bus.redirect) begin
            w_imem_addr = bus.redirect_pc[31:2];
        end else if (bus.stall && r_valid_d) begin
            w_imem_addr = r_pc_d;
        end
    end

    // Track the address the ROM is returning and the next sequential address.
    // Also count each instruction that the consumer accepts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC[31:2];
            r_pc_d        <= RESET_PC[31:2];
            r_valid_d     <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_pc_d     <= w_imem_addr;
            r_fetch_pc <= w_imem_addr + 30'd1;
            r_valid_d  <= 1'b1;
            if (r_valid_d && !bus.stall) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign bus.imem_addr   = w_imem_addr;
    assign bus.if_valid    = r_valid_d;
    assign bus.if_pc       = {r_pc_d, 2'b00};
    assign bus.if_inst     = r_valid_d ? bus.imem_inst : 32'h0;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage. It runs a directed vector table for the reset,
// stall, redirect and wrap corner cases. It then runs a randomized phase that
// is checked against a PC-stream reference model.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h00000000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fetch_stage_if bus ();

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: a few fixed words, everything else a fixed scramble of the address.
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'h0:   return 32'h3c1d1000;
            30'h1:   return 32'h0c000057;
            30'h2:   return 32'h37bd4000;
            30'h3:   return 32'h27bdffe8;
            30'h57:  return 32'h27bdffc0;
            default: return {a, 2'b11} ^ 32'h5a5a1234;
        endcase
    endfunction

    // Registered-address instruction ROM
    always @(posedge clk) bus.imem_inst <= rom_word(bus.imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Directed vectors: inputs applied before an edge, outputs expected after it.
    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] rp;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] rp,
                       input logic ev, input logic [31:0] epc, input logic [31:0] ecnt);
        vec_t v;
        v.rst = r; v.stall = s; v.redirect = rd; v.rp = rp;
        v.ev = ev; v.epc = epc; v.ecnt = ecnt;
        v.einst = ev ? rom_word(epc[31:2]) : 32'h0;
        vecs.push_back(v);
    endtask

    // Reference model state: what is on display and where sequential fetch continues.
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_next;
    logic [31:0] m_cnt;

    initial begin
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        n_cmp = 0;
        n_err = 0;
        repeat (2) @(posedge clk);
        #1;

        // Startup from reset, with four sequential instructions
        add(1,0,0,0,          0, 32'h0,   0);
        add(0,0,0,0,          1, 32'h0,   0);
        add(0,0,0,0,          1, 32'h4,   1);
        add(0,0,0,0,          1, 32'h8,   2);
        add(0,0,0,0,          1, 32'hC,   3);
        add(0,0,0,0,          1, 32'h10,  4);
        // Stall held three cycles at 0x8
        add(1,0,0,0,          0, 32'h0,   0);
        add(0,0,0,0,          1, 32'h0,   0);
        add(0,0,0,0,          1, 32'h4,   1);
        add(0,0,0,0,          1, 32'h8,   2);
        add(0,1,0,0,          1, 32'h8,   2);
        add(0,1,0,0,          1, 32'h8,   2);
        add(0,1,0,0,          1, 32'h8,   2);
        add(0,0,0,0,          1, 32'hC,   3);
        // Redirect from 0x4 to 0x15C
        add(1,0,0,0,          0, 32'h0,   0);
        add(0,0,0,0,          1, 32'h0,   0);
        add(0,0,0,0,          1, 32'h4,   1);
        add(0,0,1,32'h15C,    1, 32'h15C, 2);
        add(0,0,0,0,          1, 32'h160, 3);
        // Redirect together with stall to a misaligned target
        add(0,1,1,32'h1BE,    1, 32'h1BC, 3);
        add(0,0,0,0,          1, 32'h1C0, 4);
        // Reset during a stall at 0x40; a stall on the bubble does not hold it
        add(0,0,1,32'h40,     1, 32'h40,  5);
        add(0,1,0,0,          1, 32'h40,  5);
        add(1,1,0,0,          0, 32'h0,   0);
        add(0,1,0,0,          1, 32'h0,   0);
        add(0,0,0,0,          1, 32'h4,   1);
        // Back-to-back redirects
        add(0,0,1,32'h100,    1, 32'h100, 2);
        add(0,0,1,32'h200,    1, 32'h200, 3);
        add(0,0,0,0,          1, 32'h204, 4);
        // Address wrap at the top of memory
        add(0,0,1,32'hFFFFFFF8, 1, 32'hFFFFFFF8, 5);
        add(0,0,0,0,          1, 32'hFFFFFFFC, 6);
        add(0,0,0,0,          1, 32'h0,   7);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            bus.stall = vecs[i].stall;
            bus.redirect = vecs[i].redirect;
            bus.redirect_pc = vecs[i].rp;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d valid", i), {31'b0, bus.if_valid}, {31'b0, vecs[i].ev});
            check($sformatf("vec%0d pc", i), bus.if_pc, vecs[i].epc);
            check($sformatf("vec%0d inst", i), bus.if_inst, vecs[i].einst);
            check($sformatf("vec%0d count", i), bus.fetch_count, vecs[i].ecnt);
        end

        // Randomized phase; the first cycle is a reset so the model starts in step
        m_valid = 1'b0; m_pc = RESET_PC; m_next = RESET_PC; m_cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] exp_addr;
            rst = (c == 0) || ($urandom_range(0, 63) == 0);
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.redirect = ($urandom_range(0, 7) == 0);
            bus.redirect_pc = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15)) : $urandom;
            #1;
            if (rst) exp_addr = RESET_PC;
            else if (bus.redirect) exp_addr = bus.redirect_pc;
            else if (bus.stall && m_valid) exp_addr = m_pc;
            else exp_addr = m_next;
            check($sformatf("rnd%0d imem_addr", c), {2'b00, bus.imem_addr}, {2'b00, exp_addr[31:2]});

            // Advance the model across the edge
            if (rst) begin
                m_valid = 1'b0; m_pc = RESET_PC; m_next = RESET_PC; m_cnt = 0;
            end else begin
                if (m_valid && !bus.stall) m_cnt = m_cnt + 1;
                if (bus.redirect) begin
                    m_pc = {bus.redirect_pc[31:2], 2'b00};
                end else if (!(bus.stall && m_valid)) begin
                    m_pc = m_next;
                end
                m_next = m_pc + 32'd4;
                m_valid = 1'b1;
            end

            @(posedge clk);
            #1;
            check($sformatf("rnd%0d valid", c), {31'b0, bus.if_valid}, {31'b0, m_valid});
            check($sformatf("rnd%0d pc", c), bus.if_pc, m_pc);
            check($sformatf("rnd%0d inst", c), bus.if_inst, m_valid ? rom_word(m_pc[31:2]) : 32'h0);
            check($sformatf("rnd%0d count", c), bus.fetch_count, m_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
